// File: rtl/stream_max_min_if.sv
// stream_max_min_if: sample stream handshake and frame result bundle
interface stream_max_min_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 16
);
  logic                     clear;
  logic                     in_valid;
  logic [WIDTH-1:0]         in_data;
  logic                     in_ready;
  logic [WIDTH-1:0]         max_out;
  logic [WIDTH-1:0]         min_out;
  logic [$clog2(COUNT)-1:0] max_idx;
  logic                     done;
  logic                     busy;
  modport master (output clear, in_valid, in_data,
                  input  in_ready, max_out, min_out, max_idx, done, busy);
  modport slave  (input  clear, in_valid, in_data,
                  output in_ready, max_out, min_out, max_idx, done, busy);
endinterface

// File: rtl/stream_max_min.sv
// stream_max_min: per-frame max/min/argmax over a valid/ready sample stream
module stream_max_min #(
  parameter int WIDTH  = 8,
  parameter int COUNT  = 16,
  parameter bit SIGNED = 1'b0
) (
  input logic             clk,
  input logic             rst,
  stream_max_min_if.slave s
);
  localparam int IW = $clog2(COUNT);
  localparam int CW = IW + 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wmax_q, wmax_d, wmin_q, wmin_d, max_q, max_d, min_q, min_d;
  logic [IW-1:0]    widx_q, widx_d, idx_q, idx_d;
  logic             accept, gt, lt;
  logic [WIDTH-1:0] nmax, nmin;
  logic [IW-1:0]    nidx;
  assign s.in_ready = (state_q != DONE) & ~s.clear;
  assign accept     = s.in_valid & s.in_ready;
  assign gt   = SIGNED ? ($signed(s.in_data) > $signed(wmax_q)) : (s.in_data > wmax_q);
  assign lt   = SIGNED ? ($signed(s.in_data) < $signed(wmin_q)) : (s.in_data < wmin_q);
  assign nmax = gt ? s.in_data : wmax_q;
  assign nmin = lt ? s.in_data : wmin_q;
  assign nidx = gt ? cnt_q[IW-1:0] : widx_q;
  assign s.max_out = max_q;
  assign s.min_out = min_q;
  assign s.max_idx = idx_q;
  assign s.done    = state_q == DONE;
  assign s.busy    = state_q != IDLE;
  // Next-state: clear aborts the frame; the DONE state lasts one cycle and blocks input
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wmax_d  = wmax_q;
    wmin_d  = wmin_q;
    widx_d  = widx_q;
    max_d   = max_q;
    min_d   = min_q;
    idx_d   = idx_q;
    if (s.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          wmax_d  = s.in_data;
          wmin_d  = s.in_data;
          widx_d  = '0;
          cnt_d   = CW'(1);
          state_d = ACCUM;
        end
        ACCUM: if (accept) begin
          wmax_d = nmax;
          wmin_d = nmin;
          widx_d = nidx;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(COUNT - 1)) begin
            max_d   = nmax;
            min_d   = nmin;
            idx_d   = nidx;
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end
  // State, working and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wmax_q  <= '0;
      wmin_q  <= '0;
      widx_q  <= '0;
      max_q   <= '0;
      min_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wmax_q  <= wmax_d;
      wmin_q  <= wmin_d;
      widx_q  <= widx_d;
      max_q   <= max_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
    end
  end
endmodule
